dcache_set_store: RTL and testbench
===================================

DCACHE_SET_STORE -- requirements
Module: dcache_set_store

Interface
REQ-001 SHALL have parameter INDEX_SIZE, default 6: set index width; SETS = 2**INDEX_SIZE.
REQ-002 SHALL have parameter WORD_OFF_SIZE, default 4: word offset width; WORDS = 2**WORD_OFF_SIZE; LINE_W = 32*WORDS.
REQ-003 SHALL have parameter TAG_SIZE, default 20: tag width.
REQ-004 SHALL have parameter WAYS, default 2, legal values 1, 2 or 4: associativity; WAY_W = max(1, log2(WAYS)).
REQ-005 SHALL have ports: clk, input, 1, clock; resetn, input, 1, reset (synchronous, active-low).
REQ-006 SHALL have read-request ports: rd_en, input, 1; rd_index, input, INDEX_SIZE; rd_tag, input, TAG_SIZE.
REQ-007 SHALL have read-response outputs: rd_vld 1; hit 1; hit_way WAY_W; rd_data LINE_W; victim_way WAY_W; victim_tag TAG_SIZE; victim_valid 1; victim_dirty 1.
REQ-008 SHALL have write ports: wr_en 1; wr_index INDEX_SIZE; wr_way WAY_W; wr_tag TAG_SIZE; wr_data LINE_W; wr_strb WORDS (one bit per 32-bit word); wr_valid 1; wr_dirty 1; wr_refill 1.
REQ-009 SHALL have maintenance ports: inv_all, input, 1 (start invalidate sweep); busy, output, 1.

Function
REQ-010 SHALL return a read with 1-cycle latency: rd_en sampled at edge N while idle gives rd_vld=1 and all response fields valid after edge N+1; otherwise rd_vld=0 and the response fields hold their previous values.
REQ-011 SHALL assert hit when any way of rd_index is valid and its tag equals rd_tag; hit_way = lowest matching way index.
REQ-012 SHALL drive rd_data from the hit way on a hit, and from victim_way on a miss.
REQ-013 SHALL drive victim_way from the per-set round-robin pointer, with victim_tag, victim_valid and victim_dirty taken from that way.
REQ-014 SHALL, on wr_en while idle, write wr_tag, wr_valid and wr_dirty into (wr_index, wr_way) unconditionally, and write data word k only where wr_strb[k]=1; an all-zero strobe updates metadata only.
REQ-015 SHALL, on wr_en & wr_refill, set victim pointer[wr_index] to (wr_way+1) mod WAYS; with WAYS=1 the pointer is constant 0.
REQ-016 SHALL implement FSM IDLE/SWEEP: inv_all in IDLE -> SWEEP with counter=0; each SWEEP cycle clears valid, dirty and victim pointer of set[counter] across all ways and increments counter; at counter=SETS-1 -> IDLE.
REQ-017 SHALL drive busy=1 throughout SWEEP; a sweep lasts exactly SETS cycles; busy falls on the edge that returns the FSM to IDLE.
REQ-018 SHALL ignore rd_en, wr_en and inv_all while busy=1 (no state change, rd_vld=0).
REQ-019 SHALL give priority to inv_all over rd_en/wr_en sampled in the same IDLE cycle; the coincident read and write are dropped.
REQ-020 SHALL not modify tag or data arrays during a sweep.

Reset
REQ-021 SHALL, with resetn=0 at a clk edge, clear all valid bits, dirty bits and victim pointers, set FSM=IDLE and counter=0, and drive rd_vld, hit, hit_way, rd_data, victim_* and busy to 0.
REQ-022 SHALL abort an in-progress sweep when reset is applied; the tag and data arrays are not reset.

Configuration
REQ-023 SHALL honour macro DCACHE_SET_STORE_FWD_EN: when defined, a read and write to the same set in the same cycle return post-write tag/valid/dirty/data (strobe-merged) and use the updated victim pointer.
REQ-024 SHALL, without DCACHE_SET_STORE_FWD_EN, return pre-write contents in that same-set read/write case.

Verification
REQ-025 SHALL cover: reset, then read index 5, tag 0x12345 -> rd_vld=1, hit=0, victim_way=0, victim_valid=0 one cycle later.
REQ-026 SHALL cover: write idx 5, way 1, tag 0xABCDE, strb all-ones, data word0=0xDEADBEEF, valid=1, dirty=1, refill=1; then read idx 5, tag 0xABCDE -> hit=1, hit_way=1, rd_data[31:0]=0xDEADBEEF, victim_way=0.
REQ-027 SHALL cover: partial write strb=0x0002, word1=0x11111111 to the same line -> word0 stays 0xDEADBEEF, word1=0x11111111.
REQ-028 SHALL cover: inv_all pulse -> busy=1 for exactly 64 cycles; a read during busy gives rd_vld=0; a read after the sweep to idx 5, tag 0xABCDE gives hit=0, victim_dirty=0.
REQ-029 SHALL cover: same-cycle write (idx 3, tag 0x00001, valid=1) and read (idx 3, tag 0x00001) -> hit=1 with DCACHE_SET_STORE_FWD_EN defined, hit=0 without it.
REQ-030 SHALL cover: resetn=0 at sweep cycle 10 -> busy=0 next cycle; all valid bits 0 afterwards.

Source files
------------

// File: rtl/dcache_set_store.sv
// Set-associative cache store: tag/data/valid/dirty arrays, 1-cycle registered read with
// hit and victim info, strobed writes, per-set round-robin victim pointer and invalidate sweep.
// Optional macro DCACHE_SET_STORE_FWD_EN: same-cycle same-set write is forwarded to the read.
module dcache_set_store #(
    parameter int  INDEX_SIZE    = 6,
    parameter int  WORD_OFF_SIZE = 4,
    parameter int  TAG_SIZE      = 20,
    parameter int  WAYS          = 2,
    localparam int SETS          = 2**INDEX_SIZE,
    localparam int WORDS         = 2**WORD_OFF_SIZE,
    localparam int LINE_W        = 32*WORDS,
    localparam int WAY_W         = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  rd_en,
    input  logic [INDEX_SIZE-1:0] rd_index,
    input  logic [TAG_SIZE-1:0]   rd_tag,
    output logic                  rd_vld,
    output logic                  hit,
    output logic [WAY_W-1:0]      hit_way,
    output logic [LINE_W-1:0]     rd_data,
    output logic [WAY_W-1:0]      victim_way,
    output logic [TAG_SIZE-1:0]   victim_tag,
    output logic                  victim_valid,
    output logic                  victim_dirty,
    input  logic                  wr_en,
    input  logic [INDEX_SIZE-1:0] wr_index,
    input  logic [WAY_W-1:0]      wr_way,
    input  logic [TAG_SIZE-1:0]   wr_tag,
    input  logic [LINE_W-1:0]     wr_data,
    input  logic [WORDS-1:0]      wr_strb,
    input  logic                  wr_valid,
    input  logic                  wr_dirty,
    input  logic                  wr_refill,
    input  logic                  inv_all,
    output logic                  busy
);

    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

    state_t                    state_q, state_d;
    logic [INDEX_SIZE-1:0]     cnt_q, cnt_d;
    logic [WAYS-1:0][SETS-1:0] valid_q, valid_d;
    logic [WAYS-1:0][SETS-1:0] dirty_q, dirty_d;
    logic [SETS-1:0][WAY_W-1:0] ptr_q, ptr_d;

    // Tag and data arrays carry no reset and are untouched by the sweep.
    logic [TAG_SIZE-1:0] tag_mem  [WAYS][SETS];
    logic [LINE_W-1:0]   data_mem [WAYS][SETS];

    logic                rd_vld_q, rd_vld_d;
    logic                hit_q, hit_d;
    logic [WAY_W-1:0]    hit_way_q, hit_way_d;
    logic [LINE_W-1:0]   rd_data_q, rd_data_d;
    logic [WAY_W-1:0]    victim_way_q, victim_way_d;
    logic [TAG_SIZE-1:0] victim_tag_q, victim_tag_d;
    logic                victim_valid_q, victim_valid_d;
    logic                victim_dirty_q, victim_dirty_d;

    logic             idle, wr_way_ok, rd_acc, wr_acc;
    logic [WAY_W-1:0] ptr_nxt;

    assign idle      = (state_q == ST_IDLE);
    assign wr_way_ok = (WAYS == (1 << WAY_W)) || (wr_way == '0);
    assign rd_acc    = idle && rd_en && !inv_all;
    assign wr_acc    = resetn && idle && wr_en && !inv_all && wr_way_ok;
    assign ptr_nxt   = (WAYS == 1) ? '0 : WAY_W'(wr_way + 1'b1);

    function automatic logic [LINE_W-1:0] merge_line(input logic [LINE_W-1:0] old_l,
                                                     input logic [LINE_W-1:0] new_l,
                                                     input logic [WORDS-1:0]  strb);
        logic [LINE_W-1:0] r;
        r = old_l;
        for (int k = 0; k < WORDS; k++)
            if (strb[k]) r[32*k +: 32] = new_l[32*k +: 32];
        return r;
    endfunction

    // Control FSM and metadata next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (inv_all) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end else if (wr_acc) begin
                    valid_d[wr_way][wr_index] = wr_valid;
                    dirty_d[wr_way][wr_index] = wr_dirty;
                    if (wr_refill) ptr_d[wr_index] = ptr_nxt;
                end
            end
            ST_SWEEP: begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_d[w][cnt_q] = 1'b0;
                    dirty_d[w][cnt_q] = 1'b0;
                end
                ptr_d[cnt_q] = '0;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == INDEX_SIZE'(SETS-1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-way view of the addressed set, optionally with the concurrent write applied
    logic [TAG_SIZE-1:0] v_tag  [WAYS];
    logic [LINE_W-1:0]   v_data [WAYS];
    logic [WAYS-1:0]     v_valid, v_dirty;
    logic [WAY_W-1:0]    v_ptr;

    always_comb begin
        for (int w = 0; w < WAYS; w++) begin
            v_tag[w]   = tag_mem[w][rd_index];
            v_data[w]  = data_mem[w][rd_index];
            v_valid[w] = valid_q[w][rd_index];
            v_dirty[w] = dirty_q[w][rd_index];
        end
        v_ptr = ptr_q[rd_index];
`ifdef DCACHE_SET_STORE_FWD_EN
        if (wr_acc && (wr_index == rd_index)) begin
            v_tag[wr_way]   = wr_tag;
            v_valid[wr_way] = wr_valid;
            v_dirty[wr_way] = wr_dirty;
            v_data[wr_way]  = merge_line(data_mem[wr_way][wr_index], wr_data, wr_strb);
            if (wr_refill) v_ptr = ptr_nxt;
        end
`else
        if (1'b0) v_data[0] = merge_line(wr_data, wr_data, wr_strb);
`endif
    end

    logic             hit_c;
    logic [WAY_W-1:0] hit_way_c;

    // Descending scan so the lowest matching way wins
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        for (int w = WAYS-1; w >= 0; w--) begin
            if (v_valid[w] && (v_tag[w] == rd_tag)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
        end
    end

    always_comb begin
        rd_vld_d       = 1'b0;
        hit_d          = hit_q;
        hit_way_d      = hit_way_q;
        rd_data_d      = rd_data_q;
        victim_way_d   = victim_way_q;
        victim_tag_d   = victim_tag_q;
        victim_valid_d = victim_valid_q;
        victim_dirty_d = victim_dirty_q;
        if (rd_acc) begin
            rd_vld_d       = 1'b1;
            hit_d          = hit_c;
            hit_way_d      = hit_way_c;
            rd_data_d      = hit_c ? v_data[hit_way_c] : v_data[v_ptr];
            victim_way_d   = v_ptr;
            victim_tag_d   = v_tag[v_ptr];
            victim_valid_d = v_valid[v_ptr];
            victim_dirty_d = v_dirty[v_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            valid_q        <= '0;
            dirty_q        <= '0;
            ptr_q          <= '0;
            rd_vld_q       <= 1'b0;
            hit_q          <= 1'b0;
            hit_way_q      <= '0;
            rd_data_q      <= '0;
            victim_way_q   <= '0;
            victim_tag_q   <= '0;
            victim_valid_q <= 1'b0;
            victim_dirty_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            valid_q        <= valid_d;
            dirty_q        <= dirty_d;
            ptr_q          <= ptr_d;
            rd_vld_q       <= rd_vld_d;
            hit_q          <= hit_d;
            hit_way_q      <= hit_way_d;
            rd_data_q      <= rd_data_d;
            victim_way_q   <= victim_way_d;
            victim_tag_q   <= victim_tag_d;
            victim_valid_q <= victim_valid_d;
            victim_dirty_q <= victim_dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            tag_mem[wr_way][wr_index] <= wr_tag;
            for (int k = 0; k < WORDS; k++)
                if (wr_strb[k]) data_mem[wr_way][wr_index][32*k +: 32] <= wr_data[32*k +: 32];
        end
    end

    assign rd_vld       = rd_vld_q;
    assign hit          = hit_q;
    assign hit_way      = hit_way_q;
    assign rd_data      = rd_data_q;
    assign victim_way   = victim_way_q;
    assign victim_tag   = victim_tag_q;
    assign victim_valid = victim_valid_q;
    assign victim_dirty = victim_dirty_q;
    assign busy         = (state_q == ST_SWEEP);

endmodule

// File: tb/tb_dcache_set_store.sv
// Directed bench for dcache_set_store: stimulus pushes expected read responses into a
// queue; a negedge monitor pops and compares whenever rd_vld is seen.
module tb_dcache_set_store;

    logic           clk = 1'b0;
    logic           resetn;
    logic           rd_en;
    logic [5:0]     rd_index;
    logic [19:0]    rd_tag;
    logic           rd_vld, hit;
    logic [0:0]     hit_way, victim_way;
    logic [511:0]   rd_data;
    logic [19:0]    victim_tag;
    logic           victim_valid, victim_dirty;
    logic           wr_en;
    logic [5:0]     wr_index;
    logic [0:0]     wr_way;
    logic [19:0]    wr_tag;
    logic [511:0]   wr_data;
    logic [15:0]    wr_strb;
    logic           wr_valid, wr_dirty, wr_refill;
    logic           inv_all, busy;

    always #5 clk = ~clk;

    dcache_set_store dut (
        .clk(clk), .resetn(resetn),
        .rd_en(rd_en), .rd_index(rd_index), .rd_tag(rd_tag),
        .rd_vld(rd_vld), .hit(hit), .hit_way(hit_way), .rd_data(rd_data),
        .victim_way(victim_way), .victim_tag(victim_tag),
        .victim_valid(victim_valid), .victim_dirty(victim_dirty),
        .wr_en(wr_en), .wr_index(wr_index), .wr_way(wr_way), .wr_tag(wr_tag),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid),
        .wr_dirty(wr_dirty), .wr_refill(wr_refill),
        .inv_all(inv_all), .busy(busy)
    );

    typedef struct {
        string       name;
        logic        hit;
        logic [0:0]  hit_way;
        logic        chk_data;
        logic [31:0] w0, w1;
        logic [0:0]  vway;
        logic        chk_vtag;
        logic [19:0] vtag;
        logic        vvalid, vdirty;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response is matched against the oldest outstanding expectation
    always @(negedge clk) begin
        if (resetn === 1'b1 && rd_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rd_vld", 64'(rd_vld), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, ".hit"}, 64'(hit), 64'(e.hit));
                if (e.hit) chk({e.name, ".hit_way"}, 64'(hit_way), 64'(e.hit_way));
                if (e.chk_data) begin
                    chk({e.name, ".w0"}, 64'(rd_data[31:0]), 64'(e.w0));
                    chk({e.name, ".w1"}, 64'(rd_data[63:32]), 64'(e.w1));
                end
                chk({e.name, ".victim_way"}, 64'(victim_way), 64'(e.vway));
                if (e.chk_vtag) chk({e.name, ".victim_tag"}, 64'(victim_tag), 64'(e.vtag));
                chk({e.name, ".victim_valid"}, 64'(victim_valid), 64'(e.vvalid));
                chk({e.name, ".victim_dirty"}, 64'(victim_dirty), 64'(e.vdirty));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        inv_all = 1'b0;
    endtask

    task automatic set_rd(input logic [5:0] idx, input logic [19:0] tag);
        rd_en    = 1'b1;
        rd_index = idx;
        rd_tag   = tag;
    endtask

    task automatic set_wr(input logic [5:0] idx, input logic [0:0] way, input logic [19:0] tag,
                          input logic [15:0] strb, input logic [511:0] data,
                          input logic v, input logic d, input logic refill);
        wr_en     = 1'b1;
        wr_index  = idx;
        wr_way    = way;
        wr_tag    = tag;
        wr_strb   = strb;
        wr_data   = data;
        wr_valid  = v;
        wr_dirty  = d;
        wr_refill = refill;
    endtask

    task automatic expect_rd(input string name, input logic h, input logic [0:0] hw,
                             input logic cd, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [0:0] vw, input logic cvt, input logic [19:0] vt,
                             input logic vv, input logic vd);
        exp_t e;
        e.name = name; e.hit = h; e.hit_way = hw; e.chk_data = cd; e.w0 = w0; e.w1 = w1;
        e.vway = vw; e.chk_vtag = cvt; e.vtag = vt; e.vvalid = vv; e.vdirty = vd;
        exp_q.push_back(e);
    endtask

    function automatic logic [511:0] line_of(input logic [31:0] w0, input logic [31:0] w1);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = 32'hA000_0000 + 32'(k);
        l[31:0]  = w0;
        l[63:32] = w1;
        return l;
    endfunction

    logic fwd_hit;
    int   bcnt;

    initial begin
`ifdef DCACHE_SET_STORE_FWD_EN
        fwd_hit = 1'b1;
`else
        fwd_hit = 1'b0;
`endif
        resetn = 1'b0; rd_en = 0; rd_index = '0; rd_tag = '0;
        wr_en = 0; wr_index = '0; wr_way = '0; wr_tag = '0; wr_data = '0; wr_strb = '0;
        wr_valid = 0; wr_dirty = 0; wr_refill = 0; inv_all = 0;
        cyc(); cyc();
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.rd_vld", 64'(rd_vld), 64'd0);
        chk("rst.hit", 64'(hit), 64'd0);
        chk("rst.victim", 64'({victim_way, victim_tag, victim_valid, victim_dirty}), 64'd0);
        chk("rst.rd_data", 64'(rd_data[63:0]), 64'd0);
        resetn = 1'b1;
        cyc();

        // Cold miss on a freshly reset set
        set_rd(6'd5, 20'h12345);
        expect_rd("cold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();

        // Full refill into way 1; pointer wraps back to 0
        set_wr(6'd5, 1'b1, 20'hABCDE, 16'hFFFF, line_of(32'hDEADBEEF, 32'hA0000001), 1, 1, 1);
        cyc();
        set_rd(6'd5, 20'hABCDE);
        expect_rd("refill", 1, 1, 1, 32'hDEADBEEF, 32'hA0000001, 0, 0, 0, 0, 0);
        cyc();

        // Partial strobe only touches word 1
        set_wr(6'd5, 1'b1, 20'hABCDE, 16'h0002, line_of(32'h0, 32'h11111111), 1, 1, 0);
        cyc();
        set_rd(6'd5, 20'hABCDE);
        expect_rd("partial", 1, 1, 1, 32'hDEADBEEF, 32'h11111111, 0, 0, 0, 0, 0);
        cyc();

        // Refill way 0 moves the pointer to way 1; a miss returns way 1 as victim/data
        set_wr(6'd5, 1'b0, 20'h00777, 16'hFFFF, line_of(32'h77777777, 32'h7), 1, 0, 1);
        cyc();
        set_rd(6'd5, 20'h55555);
        expect_rd("miss_victim", 0, 0, 1, 32'hDEADBEEF, 32'h11111111, 1, 1, 20'hABCDE, 1, 1);
        cyc();

        // Both ways match: lowest way wins; then a zero-strobe write leaves data intact
        set_wr(6'd7, 1'b1, 20'h00042, 16'hFFFF, line_of(32'hBBBB0001, 32'h1), 1, 0, 0);
        cyc();
        set_wr(6'd7, 1'b0, 20'h00042, 16'hFFFF, line_of(32'hAAAA0000, 32'h0), 1, 0, 0);
        cyc();
        set_rd(6'd7, 20'h00042);
        expect_rd("lowest_way", 1, 0, 1, 32'hAAAA0000, 32'h0, 0, 0, 0, 1, 0);
        cyc();
        set_wr(6'd7, 1'b0, 20'h00042, 16'h0000, line_of(32'hCCCCCCCC, 32'hC), 1, 1, 0);
        cyc();
        set_rd(6'd7, 20'h00042);
        expect_rd("meta_only", 1, 0, 1, 32'hAAAA0000, 32'h0, 0, 1, 20'h00042, 1, 1);
        cyc();

        // Same-cycle read/write to set 3
        set_wr(6'd3, 1'b0, 20'h00001, 16'hFFFF, line_of(32'h33333333, 32'h3), 1, 0, 0);
        set_rd(6'd3, 20'h00001);
        expect_rd("same_cycle", fwd_hit, 0, fwd_hit, 32'h33333333, 32'h3, 0, 0, 0, fwd_hit, 0);
        cyc();
        set_rd(6'd3, 20'h00001);
        expect_rd("after_same", 1, 0, 1, 32'h33333333, 32'h3, 0, 0, 0, 1, 0);
        cyc();

        // Sweep: coincident read/write dropped; accesses during busy ignored
        inv_all = 1'b1;
        set_rd(6'd3, 20'h00001);
        set_wr(6'd9, 1'b0, 20'h00099, 16'hFFFF, '0, 1, 1, 1);
        cyc();
        bcnt = 0;
        while (busy === 1'b1 && bcnt < 200) begin
            if (bcnt == 10) begin
                set_rd(6'd5, 20'hABCDE);
                set_wr(6'd5, 1'b0, 20'hABCDE, 16'h0000, '0, 1, 1, 1);
                inv_all = 1'b1;
            end
            cyc();
            bcnt++;
        end
        chk("sweep.busy_cycles", 64'(bcnt), 64'd64);
        set_rd(6'd5, 20'hABCDE);
        expect_rd("post_sweep5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        set_rd(6'd9, 20'h00099);
        expect_rd("post_sweep9", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();

        // Reset mid-sweep aborts it and clears metadata the sweep had not reached
        set_wr(6'd40, 1'b0, 20'h00040, 16'hFFFF, '0, 1, 1, 1);
        cyc();
        inv_all = 1'b1;
        cyc();
        for (int i = 0; i < 10; i++) cyc();
        chk("sweep10.busy", 64'(busy), 64'd1);
        resetn = 1'b0;
        cyc();
        chk("rst_sweep.busy", 64'(busy), 64'd0);
        chk("rst_sweep.rd_vld", 64'(rd_vld), 64'd0);
        resetn = 1'b1;
        cyc();
        chk("rst_sweep.idle", 64'(busy), 64'd0);
        set_rd(6'd40, 20'h00040);
        expect_rd("post_rst40", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        cyc(); cyc();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
